// File: rtl/div3_pkg.sv
// div3_pkg: shared types and helpers for the divisible-by-3 request arbiter.
package div3_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

    function automatic int next_rr(input int ptr, input int n);
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/div3_rr_pick.sv
// div3_rr_pick: combinational round-robin picker, scanning upward from prio_ptr modulo N_REQ.
module div3_rr_pick #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  prio_ptr,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_idx
);

    int idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(prio_ptr) + k) % N_REQ;
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/div_by_3_checker.sv
// div_by_3_checker: combinational unsigned word mod-3 test, folding the remainder MSB-first.
module div_by_3_checker #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    output logic              divisible
);

    logic [1:0] rem;
    logic [2:0] acc;

    // rem stays in 0..2, so {rem, bit} is at most 5 and one conditional subtract reduces it
    always_comb begin
        rem = 2'd0;
        acc = 3'd0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            acc = {rem, data[i]};
            rem = (acc >= 3'd3) ? 2'(acc - 3'd3) : acc[1:0];
        end
        divisible = (rem == 2'd0);
    end

endmodule

// File: rtl/div3_req_arbiter.sv
// div3_req_arbiter: round-robin arbiter sharing one mod-3 checker among N_REQ requesters,
// returning a registered, id-tagged verdict on a valid/ready response channel.
module div3_req_arbiter
    import div3_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_divisible
);

    rsp_state_t       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             div_q, div_d;
    logic             grant_valid, grant, divisible;
    logic [ID_W-1:0]  grant_idx;
    logic [DATA_W-1:0] sel_data;

    div3_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_valid  (req_valid),
        .prio_ptr   (ptr_q),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    assign sel_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

    div_by_3_checker #(.DATA_W(DATA_W)) u_chk (
        .data     (sel_data),
        .divisible(divisible)
    );

    // gating by rst_n keeps reset cycles grant-free, since reset only lands at the edge
    assign grant = rst_n && ((state_q == EMPTY) || rsp_ready) && grant_valid;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[grant_idx] = 1'b1;
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        div_d   = div_q;
        if (grant) begin
            state_d = FULL;
            ptr_d   = ID_W'(next_rr(int'(grant_idx), N_REQ));
            id_d    = grant_idx;
            div_d   = divisible;
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            div_q   <= div_d;
        end
    end

    assign rsp_valid     = (state_q == FULL);
    assign rsp_id        = id_q;
    assign rsp_divisible = div_q;

endmodule

// File: tb/tb_div3_req_arbiter.sv
// tb_div3_req_arbiter: table-driven directed vectors plus a short bounded hand sequence.
module tb_div3_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  exp_rr;
        logic        chk_rsp;
        logic        exp_v;
        logic [1:0]  exp_id;
        logic        exp_d;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic          rsp_divisible;

    int total = 0;
    int passed = 0;
    vec_t tbl[$];

    div3_req_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_divisible(rsp_divisible)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s row %0d: got %0h want %0h", name, row, got, exp);
        else passed++;
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic rdy,
                       input logic [3:0] err, input logic c, input logic ev, input logic [1:0] eid, input logic ed);
        vec_t x;
        x.rst_n = r; x.valid = v; x.data = d; x.rdy = rdy; x.exp_rr = err;
        x.chk_rsp = c; x.exp_v = ev; x.exp_id = eid; x.exp_d = ed;
        tbl.push_back(x);
    endtask

    initial begin
        bit seen;
        // words packed {w3,w2,w1,w0}; rsp_* columns are the registered values before this row's edge
        add(0, 4'b1111, 32'h00000000, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b1111, 32'h00000000, 1, 4'b0000, 1, 0, 0, 0);
        add(0, 4'b1111, 32'h00000000, 1, 4'b0000, 1, 0, 0, 0);
        add(1, 4'b0100, 32'h00090000, 1, 4'b0100, 1, 0, 0, 0);
        add(1, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 1, 2, 1);
        add(1, 4'b0100, 32'h000A0000, 1, 4'b0100, 1, 0, 2, 1);
        add(1, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 1, 2, 0);
        add(1, 4'b0100, 32'h00000000, 1, 4'b0100, 1, 0, 2, 0);
        add(1, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 1, 2, 1);
        add(1, 4'b0011, 32'h00000706, 1, 4'b0001, 1, 0, 2, 1);
        add(1, 4'b0010, 32'h00000706, 1, 4'b0010, 1, 1, 0, 1);
        add(1, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 1, 1, 0);
        add(0, 4'b1111, 32'h00FF0403, 1, 4'b0000, 1, 0, 1, 0);
        add(1, 4'b1111, 32'h00FF0403, 1, 4'b0001, 1, 0, 0, 0);
        add(1, 4'b1111, 32'h00FF0403, 1, 4'b0010, 1, 1, 0, 1);
        add(1, 4'b1111, 32'h00FF0403, 1, 4'b0100, 1, 1, 1, 0);
        add(1, 4'b1111, 32'h00FF0403, 1, 4'b1000, 1, 1, 2, 1);
        add(1, 4'b1111, 32'h00FF0403, 1, 4'b0001, 1, 1, 3, 1);
        for (int i = 0; i < 5; i++)
            add(1, 4'b1111, 32'h00FF0403, 0, 4'b0000, 1, 1, 0, 1);
        add(1, 4'b1111, 32'h00FF0403, 1, 4'b0010, 1, 1, 0, 1);
        add(1, 4'b1111, 32'h00FF0403, 0, 4'b0000, 1, 1, 1, 0);
        add(0, 4'b1111, 32'h00FF0403, 0, 4'b0000, 1, 1, 1, 0);
        add(1, 4'b0110, 32'h00FF0403, 1, 4'b0010, 1, 0, 0, 0);
        add(1, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 1, 1, 0);
        add(1, 4'b0000, 32'h00000000, 0, 4'b0000, 1, 0, 1, 0);

        foreach (tbl[i]) begin
            rst_n     = tbl[i].rst_n;
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            rsp_ready = tbl[i].rdy;
            #2;
            chk("req_ready", i, 32'(req_ready), 32'(tbl[i].exp_rr));
            if (tbl[i].chk_rsp) begin
                chk("rsp_valid", i, 32'(rsp_valid), 32'(tbl[i].exp_v));
                chk("rsp_id", i, 32'(rsp_id), 32'(tbl[i].exp_id));
                chk("rsp_divisible", i, 32'(rsp_divisible), 32'(tbl[i].exp_d));
            end
            @(posedge clk);
            #1;
        end

        // hand sequence: lone requester 3 with word 12, bounded waits for grant and response
        req_valid = 4'b1000;
        req_data  = 32'h0C000000;
        rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            #2;
            if (req_ready != 4'b0000) begin
                seen = 1;
                chk("hand_grant", c, 32'(req_ready), 32'h8);
            end
            @(posedge clk);
            #1;
        end
        if (!seen) chk("hand_grant_timeout", 0, 32'h0, 32'h1);
        req_valid = 4'b0000;
        #2;
        chk("hand_rsp_valid", 0, 32'(rsp_valid), 32'h1);
        chk("hand_rsp_id", 0, 32'(rsp_id), 32'h3);
        chk("hand_rsp_div", 0, 32'(rsp_divisible), 32'h1);
        @(posedge clk);
        #2;
        chk("hand_drain", 0, 32'(rsp_valid), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
